can_tx_scheduler: RTL and testbench

- Shares the single CAN frame generator between N_REQ requesters, such as ADC readout and custom SDO/test-message sources, in the MOPS-Hub testbench.
- Arbitrates pending requests by CAN priority: the lowest 11-bit ID wins, as on the bus.
- Loads the winning 76-bit payload into the generator and waits for frame completion.
- Enforces a bus intermission before the next frame.
- Reports timeouts and the number of frames sent.

---
 rtl/can_sched_pkg.sv | 16 +
 rtl/can_id_prio_arb.sv | 29 ++
 rtl/can_tx_scheduler.sv | 142 ++++++++++++++
 tb/tb_can_tx_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_sched_pkg.sv
// rtl/can_sched_pkg.sv - shared types, payload field positions and ID helper for the CAN TX scheduler
package can_sched_pkg;

  typedef enum logic [2:0] {IDLE, ARB, LOAD, WAIT, IFS} state_t;

  localparam int PAYLOAD_W = 76;
  localparam int ID_MSB    = 74;
  localparam int ID_LSB    = 64;
  localparam int DATA_W    = 64;
  localparam int ID_W      = 11;

  function automatic logic [ID_W-1:0] extract_id(input logic [PAYLOAD_W-1:0] payload);
    return payload[ID_MSB:ID_LSB];
  endfunction

endpackage

// File: rtl/can_id_prio_arb.sv
// rtl/can_id_prio_arb.sv - combinational lowest-CAN-ID finder; ties go to the lowest index
module can_id_prio_arb
  import can_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]      valid,
  input  logic [N_REQ*ID_W-1:0] ids,
  output logic [2:0]            winner,
  output logic                  any_valid
);

  logic [ID_W-1:0] best_id;

  // Strict less-than keeps the earlier (lower-index) slot on equal IDs.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    best_id   = '1;
    for (int k = 0; k < N_REQ; k++) begin
      if (valid[k] && (!any_valid || (ids[k*ID_W +: ID_W] < best_id))) begin
        winner    = 3'(k);
        best_id   = ids[k*ID_W +: ID_W];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// rtl/can_tx_scheduler.sv - shares one CAN frame generator between N_REQ requesters
// CAN_SCHED_RR_EN: round-robin grant instead of lowest-ID priority.
module can_tx_scheduler
  import can_sched_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int IFS_BITS       = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*PAYLOAD_W-1:0] req_payload,
  output logic [N_REQ-1:0]           req_ack,
  output logic [PAYLOAD_W-1:0]       gen_payload,
  output logic                       gen_start,
  input  logic                       gen_done,
  output logic                       busy,
  output logic [2:0]                 grant_idx,
  output logic                       timeout_err,
  output logic [15:0]                frame_cnt
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IFS_W  = (IFS_BITS > 1) ? $clog2(IFS_BITS + 1) : 1;

  state_t               state;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [IFS_W-1:0]     ifs_cnt;
  logic [15:0]          frames;
  logic [2:0]           win_idx;
  logic                 win_any;
  logic [PAYLOAD_W-1:0] sel_payload;

`ifdef CAN_SCHED_RR_EN
  // Search begins one past the last grant; grant_idx doubles as the rr pointer.
  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!win_any && req_valid[j] && (((int'(grant_idx) + 1 + off) % N_REQ) == j)) begin
          win_idx = 3'(j);
          win_any = 1'b1;
        end
      end
    end
  end
`else
  logic [N_REQ*ID_W-1:0] ids;

  for (genvar k = 0; k < N_REQ; k++) begin : g_ids
    assign ids[k*ID_W +: ID_W] = extract_id(req_payload[k*PAYLOAD_W +: PAYLOAD_W]);
  end

  can_id_prio_arb #(.N_REQ(N_REQ)) u_arb (
    .valid     (req_valid),
    .ids       (ids),
    .winner    (win_idx),
    .any_valid (win_any)
  );
`endif

  always_comb begin
    sel_payload = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_idx == 3'(k)) sel_payload = req_payload[k*PAYLOAD_W +: PAYLOAD_W];
    end
  end

  assign frame_cnt = frames;

  // Grant outputs are registered on the ARB->LOAD edge so they are valid throughout LOAD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      ifs_cnt     <= '0;
      frames      <= '0;
      req_ack     <= '0;
      gen_payload <= '0;
      gen_start   <= 1'b0;
      busy        <= 1'b0;
      grant_idx   <= '0;
      timeout_err <= 1'b0;
    end else begin
      req_ack     <= '0;
      gen_start   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          if (win_any) begin
            gen_payload <= sel_payload;
            gen_start   <= 1'b1;
            req_ack     <= N_REQ'(1) << win_idx;
            grant_idx   <= win_idx;
            state       <= LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (gen_done) begin
            frames  <= frames + 16'd1;
            ifs_cnt <= '0;
            state   <= IFS;
          end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            ifs_cnt     <= '0;
            state       <= IFS;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        IFS: begin
          if (ifs_cnt == IFS_W'(IFS_BITS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ifs_cnt <= ifs_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb/tb_can_tx_scheduler.sv - randomized self-checking bench for can_tx_scheduler
module tb_can_tx_scheduler;

  localparam int N_REQ = 4;
  localparam int IFS_BITS = 3;
  localparam int TIMEOUT_CYCLES = 256;
  localparam int PW = 76;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N_REQ-1:0] req_valid = '0;
  logic [N_REQ*PW-1:0] req_payload = '0;
  logic [N_REQ-1:0] req_ack;
  logic [PW-1:0] gen_payload;
  logic gen_start;
  logic gen_done = 1'b0;
  logic busy;
  logic [2:0] grant_idx;
  logic timeout_err;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int model_last = 0;
  logic [10:0] m_id [N_REQ];
  logic [PW-1:0] m_pay [N_REQ];

  can_tx_scheduler #(.N_REQ(N_REQ), .IFS_BITS(IFS_BITS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_payload(req_payload), .req_ack(req_ack),
    .gen_payload(gen_payload), .gen_start(gen_start), .gen_done(gen_done), .busy(busy),
    .grant_idx(grant_idx), .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference winner: smallest (id, index) key, or first valid after the last grant in rr mode.
  function automatic int ref_pick(input logic [N_REQ-1:0] pend, input int last);
    int best, best_key, key;
    best = -1;
    best_key = 0;
`ifdef CAN_SCHED_RR_EN
    for (int off = 1; off <= N_REQ; off++)
      if (best < 0 && pend[(last + off) % N_REQ]) best = (last + off) % N_REQ;
`else
    for (int k = 0; k < N_REQ; k++) begin
      key = int'(m_id[k]) * N_REQ + k;
      if (pend[k] && (best < 0 || key < best_key)) begin
        best = k;
        best_key = key;
      end
    end
`endif
    return best;
  endfunction

  task automatic make_req(input int k, input logic [10:0] id, input logic [63:0] data);
    m_id[k] = id;
    m_pay[k] = {1'($urandom_range(0, 1)), id, data};
    req_payload[k*PW +: PW] = m_pay[k];
    req_valid[k] = 1'b1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    gen_done = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_last = 0;
    @(negedge clk);
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (gen_start !== 1'b1 && lat < 400);
    if (gen_start !== 1'b1) lat = -1;
  endtask

  task automatic pulse_done();
    gen_done = 1'b1;
    @(negedge clk);
    gen_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({req_ack, gen_start, busy, timeout_err} !== '0) begin n_bad++; $display("FAIL reset_ctrl: got %b required 0", {req_ack, gen_start, busy, timeout_err}); end
    n_cmp++; if (gen_payload !== '0) begin n_bad++; $display("FAIL reset_payload: got %h required 0", gen_payload); end
    n_cmp++; if ({grant_idx, frame_cnt} !== '0) begin n_bad++; $display("FAIL reset_counts: got grant %0d frames %0d required 0", grant_idx, frame_cnt); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_single();
    int lat, n;
    do_reset();
    make_req(2, 11'h123, 64'hDEADBEEF_CAFEF00D);
    wait_start(lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL single_latency: got %0d required 2", lat); end
    n_cmp++; if (req_ack !== 4'b0100) begin n_bad++; $display("FAIL single_ack: got %b required 0100", req_ack); end
    n_cmp++; if (gen_payload !== m_pay[2]) begin n_bad++; $display("FAIL single_payload: got %h required %h", gen_payload, m_pay[2]); end
    n_cmp++; if (grant_idx !== 3'd2) begin n_bad++; $display("FAIL single_grant: got %0d required 2", grant_idx); end
    req_valid[2] = 1'b0;
    @(negedge clk);
    n_cmp++; if ({gen_start, req_ack} !== '0) begin n_bad++; $display("FAIL single_pulse_width: got %b required 0", {gen_start, req_ack}); end
    repeat (3) @(negedge clk);
    pulse_done();
    n = 1;
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL single_frame_cnt: got %0d required 1", frame_cnt); end
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++; if (n !== IFS_BITS + 1) begin n_bad++; $display("FAIL single_busy_drop: got %0d cycles required %0d", n, IFS_BITS + 1); end
    pulse_done();
    @(negedge clk);
    n_cmp++; if ({busy, frame_cnt} !== {1'b0, 16'd1}) begin n_bad++; $display("FAIL idle_done_ignored: got busy %b frames %0d required 0/1", busy, frame_cnt); end
  endtask

  task automatic test_priority();
    int lat, exp;
    logic [N_REQ-1:0] pend;
    for (int round = 0; round < 7; round++) begin
      do_reset();
      if (round == 0) begin
        make_req(0, 11'h300, {$urandom, $urandom});
        make_req(1, 11'h080, {$urandom, $urandom});
        make_req(2, 11'h080, {$urandom, $urandom});
        make_req(3, 11'h7FF, {$urandom, $urandom});
      end else begin
        for (int k = 0; k < N_REQ; k++)
          if ($urandom_range(0, 3) != 0 || k == round % N_REQ)
            make_req(k, (round % 2 == 1) ? 11'($urandom_range(0, 3)) : 11'($urandom), {$urandom, $urandom});
      end
      pend = req_valid;
      while (pend != '0) begin
        exp = ref_pick(pend, model_last);
        wait_start(lat);
        n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL prio_start r%0d: no gen_start required slot %0d", round, exp); end
        n_cmp++; if (grant_idx !== 3'(exp) || req_ack !== (4'(1) << exp)) begin n_bad++; $display("FAIL prio_grant r%0d: got idx %0d ack %b required %0d", round, grant_idx, req_ack, exp); end
        n_cmp++; if (gen_payload !== m_pay[exp]) begin n_bad++; $display("FAIL prio_payload r%0d: got %h required %h", round, gen_payload, m_pay[exp]); end
        req_valid[exp] = 1'b0;
        pend[exp] = 1'b0;
        model_last = exp;
        repeat ($urandom_range(1, 8)) @(negedge clk);
        pulse_done();
      end
    end
  endtask

  task automatic test_withdraw();
    int starts;
    do_reset();
    make_req(1, 11'h010, 64'h1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (gen_start === 1'b1 || req_ack !== '0) starts++;
    end
    n_cmp++; if (starts !== 0 || busy !== 1'b0) begin n_bad++; $display("FAIL withdraw: got %0d grants busy %b required 0/0", starts, busy); end
  endtask

  task automatic test_intermission();
    int lat;
    do_reset();
    make_req(0, 11'($urandom), {$urandom, $urandom});
    wait_start(lat);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      pulse_done();
      wait_start(lat);
      n_cmp++; if (lat + 1 !== IFS_BITS + 3) begin n_bad++; $display("FAIL ifs_spacing %0d: got %0d required %0d", i, lat + 1, IFS_BITS + 3); end
    end
    req_valid = '0;
  endtask

  task automatic test_timeout();
    int lat, n;
    logic err_seen;
    do_reset();
    make_req(1, 11'h055, {$urandom, $urandom});
    wait_start(lat);
    req_valid[1] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (timeout_err !== 1'b1 && n < 400);
    n_cmp++; if (n !== TIMEOUT_CYCLES + 1) begin n_bad++; $display("FAIL timeout_at: got %0d required %0d", n, TIMEOUT_CYCLES + 1); end
    n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL timeout_frames: got %0d required 0", frame_cnt); end
    @(negedge clk);
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse: got %b required 0", timeout_err); end
    make_req(3, 11'h222, {$urandom, $urandom});
    wait_start(lat);
    n_cmp++; if (lat < 0 || grant_idx !== 3'd3) begin n_bad++; $display("FAIL after_timeout_grant: got %0d required 3", grant_idx); end
    req_valid[3] = 1'b0;
    repeat (2) @(negedge clk);
    pulse_done();
    n_cmp++; if (frame_cnt !== 16'd1) begin n_bad++; $display("FAIL after_timeout_frames: got %0d required 1", frame_cnt); end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    make_req(2, 11'h333, {$urandom, $urandom});
    wait_start(lat);
    req_valid[2] = 1'b0;
    repeat (TIMEOUT_CYCLES) @(negedge clk);
    pulse_done();
    err_seen = 1'b0;
    repeat (4) begin
      if (timeout_err === 1'b1) err_seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (err_seen !== 1'b0 || frame_cnt !== 16'd2) begin n_bad++; $display("FAIL done_at_limit: got err %b frames %0d required 0/2", err_seen, frame_cnt); end
  endtask

  task automatic test_reset_in_wait();
    int lat, acks;
    logic [N_REQ-1:0] first_ack;
    logic [PW-1:0] first_pay;
    do_reset();
    make_req(3, 11'h044, {$urandom, $urandom});
    wait_start(lat);
    req_valid[3] = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if ({req_ack, gen_start, busy, timeout_err, grant_idx} !== '0 || gen_payload !== '0) begin n_bad++; $display("FAIL async_reset: got ack %b busy %b grant %0d payload %h required 0", req_ack, busy, grant_idx, gen_payload); end
    make_req(2, 11'h111, {$urandom, $urandom});
    @(negedge clk);
    rst = 1'b1;
    acks = 0;
    first_ack = '0;
    first_pay = '0;
    repeat (40) begin
      @(negedge clk);
      if (req_ack !== '0) begin
        if (acks == 0) begin
          first_ack = req_ack;
          first_pay = gen_payload;
        end
        acks++;
        req_valid[2] = 1'b0;
      end
    end
    n_cmp++; if (acks !== 1 || first_ack !== 4'b0100) begin n_bad++; $display("FAIL reset_regrant: got %0d acks first %b required 1 ack 0100", acks, first_ack); end
    n_cmp++; if (first_pay !== m_pay[2]) begin n_bad++; $display("FAIL reset_regrant_payload: got %h required %h", first_pay, m_pay[2]); end
  endtask

  task automatic test_wrap();
    int lat;
    do_reset();
    force dut.frames = 16'hFFFF;
    #1 release dut.frames;
    make_req(0, 11'h001, {$urandom, $urandom});
    wait_start(lat);
    req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    pulse_done();
    n_cmp++; if (frame_cnt !== 16'h0000) begin n_bad++; $display("FAIL frame_wrap: got %h required 0000", frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_withdraw();
    test_intermission();
    test_timeout();
    test_reset_in_wait();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
